// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, SPI mode constants and edge helper for spi_slave_param
//
// Contents:
//   spi_state_t   frame FSM state (IDLE, ACTIVE)
//   SPI_MODE0..3  SPI modes encoded as {CPOL,CPHA}
//   sample_level  sclk level right after the edge on which MOSI is sampled
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling one.
    function automatic logic sample_level(input logic [1:0] mode);
        case (mode)
            SPI_MODE0, SPI_MODE3: return 1'b1;
            SPI_MODE1, SPI_MODE2: return 1'b0;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - STAGES-deep flop synchroniser, cleared by reset
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-low reset
//   d    in   asynchronous input
//   q    out  synchronised output
module spi_sync
    import spi_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - oversampling SPI slave, all four modes, one-entry tx buffer
//
// Optional feature macro: SPI_TX_UNDERRUN_EN (adds tx_underrun output)
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   sclk, CS, MOSI    SPI inputs from the master (asynchronous to clk)
//   MISO              serial data out, 0 while not selected
//   tx_data/valid     word offered to the transmit buffer
//   tx_ready          transmit buffer empty
//   rx_data/valid     last received word, one-cycle update pulse
//   busy              frame in progress
//   leds              low nibble of the last received word
//   tx_underrun       (SPI_TX_UNDERRUN_EN) a word was started with the buffer empty
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic [3:0]       leds
`ifdef SPI_TX_UNDERRUN_EN
    ,
    output logic             tx_underrun
`endif
);

    localparam int   CNT_W      = $clog2(WIDTH + 1);
    localparam logic SAMPLE_LVL = sample_level({CPOL, CPHA});

    logic             sclk_s, cs_s, mosi_s;
    logic             sclk_d, cs_d;
    logic             sample_edge, shift_edge, cs_rise, cs_fall;
    spi_state_t       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift, tx_shift, tx_buf;
    logic             tx_full;
    logic             word_done, reload, tx_write;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst(rst), .d(CS),   .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst(rst), .d(MOSI), .q(mosi_s));

    // MOSI goes through the same synchroniser depth as sclk, so it stays
    // aligned with the sample edge seen here.
    assign sample_edge = (sclk_s != sclk_d) && (sclk_s == SAMPLE_LVL);
    assign shift_edge  = (sclk_s != sclk_d) && (sclk_s != SAMPLE_LVL);
    assign cs_rise     = cs_s & ~cs_d;
    assign cs_fall     = ~cs_s & cs_d;
    assign tx_ready    = ~tx_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        MISO      = 1'b0;
        word_done = 1'b0;
        reload    = 1'b0;
        tx_write  = tx_valid && !tx_full;
        case (state_q)
            IDLE: begin
                if (cs_rise) begin
                    state_d = ACTIVE;
                    reload  = 1'b1;
                end
            end
            ACTIVE: begin
                busy      = 1'b1;
                MISO      = tx_shift[WIDTH-1];
                word_done = (bit_cnt == CNT_W'(WIDTH));
                // A word that completes as CS falls is still delivered, but
                // no new word is loaded for a frame that is ending.
                reload    = word_done && !cs_fall;
                if (cs_fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_d   <= 1'b0;
            cs_d     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            leds     <= 4'h0;
        end else begin
            sclk_d   <= sclk_s;
            cs_d     <= cs_s;
            rx_valid <= 1'b0;

            // Reload looks at tx_full from before this edge, so a write in the
            // same cycle lands in the buffer for the following word.
            if (tx_write) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (reload && tx_full) begin
                tx_full <= 1'b0;
            end

            if (word_done) begin
                rx_data  <= rx_shift;
                leds     <= rx_shift[3:0];
                rx_valid <= 1'b1;
            end

            if (reload) begin
                tx_shift <= tx_full ? tx_buf : '0;
                bit_cnt  <= '0;
            end else if (state_q == ACTIVE && cs_fall) begin
                tx_shift <= '0;
                bit_cnt  <= '0;
            end else if (state_q == ACTIVE) begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                end else if (shift_edge && bit_cnt != '0) begin
                    // No shift on the first shift edge of a word: the MSB has
                    // to stay on MISO until the master has sampled it.
                    tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

`ifdef SPI_TX_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            underrun_q <= 1'b0;
        end else if (reload && !tx_full) begin
            underrun_q <= 1'b1;
        end else if (tx_write) begin
            underrun_q <= 1'b0;
        end
    end

    assign tx_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - self-checking bench for spi_slave_param in all four SPI modes
module tb_spi_slave_param;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs = 1'b0;
    logic       phase = 1'b0;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    int         sel = 0;

    logic [3:0] sclk_m, cs_m, tx_valid_m, miso_m, tx_ready_m, rx_valid_m, busy_m;
    logic [7:0] rx_data_m [4];
    logic [3:0] leds_m [4];
`ifdef SPI_TX_UNDERRUN_EN
    logic [3:0] txu_m;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int rxv_cnt = 0;
    logic [7:0] rx_hist[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam bit GPOL = bit'((g >> 1) & 1);
        localparam bit GPHA = bit'(g & 1);
        assign sclk_m[g]     = phase ^ GPOL;
        assign cs_m[g]       = cs && (sel == g);
        assign tx_valid_m[g] = tx_valid && (sel == g);
        spi_slave_param #(.WIDTH(8), .CPOL(GPOL), .CPHA(GPHA), .SYNC_STAGES(2)) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk_m[g]), .CS(cs_m[g]), .MOSI(mosi),
            .MISO(miso_m[g]), .tx_data(tx_data), .tx_valid(tx_valid_m[g]),
            .tx_ready(tx_ready_m[g]), .rx_data(rx_data_m[g]), .rx_valid(rx_valid_m[g]),
            .busy(busy_m[g]), .leds(leds_m[g])
`ifdef SPI_TX_UNDERRUN_EN
            , .tx_underrun(txu_m[g])
`endif
        );
    end

    always @(negedge clk) begin
        if (rx_valid_m[sel] === 1'b1) begin
            rxv_cnt++;
            rx_hist.push_back(rx_data_m[sel]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        while (tx_ready_m[sel] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_before_push", 32'(tx_ready_m[sel]), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_after_push", 32'(tx_ready_m[sel]), 32'd0);
    endtask

    // Master side of nbits bit times, MSB first, returning the MISO bits seen.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic cpha;
        cpha = sel[0];
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mo[7-i];
                wait_clk(H);
                mi = {mi[6:0], miso_m[sel]};
                phase = 1'b1;
                wait_clk(H);
                phase = 1'b0;
            end else begin
                phase = 1'b1;
                mosi = mo[7-i];
                wait_clk(H);
                mi = {mi[6:0], miso_m[sel]};
                phase = 1'b0;
                wait_clk(H);
            end
        end
    endtask

    typedef struct {
        int         mode;
        logic [7:0] txw;
        logic [7:0] mosiw;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        logic [3:0] exp_leds;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] mi, mi2;
        int base;

        vecs[0] = '{0, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 4'hC};
        vecs[1] = '{1, 8'h7E, 8'h81, 8'h81, 8'h7E, 4'h1};
        vecs[2] = '{2, 8'h7E, 8'h81, 8'h81, 8'h7E, 4'h1};
        vecs[3] = '{3, 8'h7E, 8'h81, 8'h81, 8'h7E, 4'h1};
        vecs[4] = '{2, 8'h01, 8'hC6, 8'hC6, 8'h01, 4'h6};

        wait_clk(4);
        check("reset_rx_data", 32'(rx_data_m[0]), 32'h0);
        check("reset_rx_valid", 32'(rx_valid_m[0]), 32'h0);
        check("reset_busy", 32'(busy_m[0]), 32'h0);
        check("reset_leds", 32'(leds_m[0]), 32'h0);
        check("reset_tx_ready", 32'(tx_ready_m[0]), 32'h1);
        check("reset_miso", 32'(miso_m[0]), 32'h0);
        rst = 1'b1;
        wait_clk(4);

        for (int v = 0; v < 5; v++) begin
            sel = vecs[v].mode;
            wait_clk(4);
            push_tx(vecs[v].txw);
            base = rxv_cnt;
            cs = 1'b1;
            wait_clk(H);
            check("busy_in_frame", 32'(busy_m[sel]), 32'h1);
            xfer(vecs[v].mosiw, 8, mi);
            wait_clk(H);
            cs = 1'b0;
            wait_clk(H);
            check("vec_rx_data", 32'(rx_data_m[sel]), 32'(vecs[v].exp_rx));
            check("vec_rx_pulses", 32'(rxv_cnt - base), 32'd1);
            check("vec_leds", 32'(leds_m[sel]), 32'(vecs[v].exp_leds));
            check("vec_miso_word", 32'(mi), 32'(vecs[v].exp_miso));
            check("vec_busy_after", 32'(busy_m[sel]), 32'h0);
        end

        // Two words in one frame, buffer refilled after the first reload.
        sel = 0;
        wait_clk(4);
        push_tx(8'h56);
        rx_hist.delete();
        base = rxv_cnt;
        cs = 1'b1;
        wait_clk(H);
        push_tx(8'h78);
        xfer(8'h12, 8, mi);
        xfer(8'h34, 8, mi2);
        wait_clk(H);
        cs = 1'b0;
        wait_clk(H);
        check("b2b_pulses", 32'(rxv_cnt - base), 32'd2);
        check("b2b_rx0", 32'(rx_hist.size() > 0 ? rx_hist[0] : 8'hXX), 32'h12);
        check("b2b_rx1", 32'(rx_hist.size() > 1 ? rx_hist[1] : 8'hXX), 32'h34);
        check("b2b_miso0", 32'(mi), 32'h56);
        check("b2b_miso1", 32'(mi2), 32'h78);

        // CS dropped after 5 bits: nothing delivered, previous word held.
        base = rxv_cnt;
        cs = 1'b1;
        wait_clk(H);
        xfer(8'hFF, 5, mi);
        cs = 1'b0;
        wait_clk(H);
        check("abort_pulses", 32'(rxv_cnt - base), 32'd0);
        check("abort_rx_data", 32'(rx_data_m[0]), 32'h34);
        check("abort_leds", 32'(leds_m[0]), 32'h4);
        check("abort_busy", 32'(busy_m[0]), 32'h0);

        // Full frame with an empty buffer: zeros on MISO.
        base = rxv_cnt;
        cs = 1'b1;
        wait_clk(H);
        xfer(8'h0F, 8, mi);
        wait_clk(H);
        cs = 1'b0;
        wait_clk(H);
        check("empty_rx_data", 32'(rx_data_m[0]), 32'h0F);
        check("empty_leds", 32'(leds_m[0]), 32'hF);
        check("empty_pulses", 32'(rxv_cnt - base), 32'd1);
        check("empty_miso_word", 32'(mi), 32'h00);
`ifdef SPI_TX_UNDERRUN_EN
        check("underrun_set", 32'(txu_m[0]), 32'h1);
`endif
        push_tx(8'h11);
`ifdef SPI_TX_UNDERRUN_EN
        check("underrun_cleared", 32'(txu_m[0]), 32'h0);
`endif

        // Reset pulse mid-frame with the buffer full.
        base = rxv_cnt;
        cs = 1'b1;
        wait_clk(H);
        push_tx(8'h22);
        xfer(8'hAA, 4, mi);
        check("pre_reset_busy", 32'(busy_m[0]), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data_m[0]), 32'h0);
        check("rst_rx_valid", 32'(rx_valid_m[0]), 32'h0);
        check("rst_busy", 32'(busy_m[0]), 32'h0);
        check("rst_leds", 32'(leds_m[0]), 32'h0);
        check("rst_tx_ready", 32'(tx_ready_m[0]), 32'h1);
        check("rst_miso", 32'(miso_m[0]), 32'h0);
        rst = 1'b1;
        wait_clk(H);
        xfer(8'hAA, 4, mi);
        wait_clk(H);
        cs = 1'b0;
        wait_clk(H);
        check("rst_discard_pulses", 32'(rxv_cnt - base), 32'd0);
        check("rst_discard_rx_data", 32'(rx_data_m[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
